// File: rtl/rat_io_ctrl_if.sv
// MCU port-mapped I/O bus between the RAT core and rat_io_ctrl.
// The core drives address, data and strobe; the controller returns read data.
interface rat_io_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input IN_PORT);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output IN_PORT);
endinterface

// File: rtl/rat_io_ctrl.sv
// Port-mapped I/O controller: N output registers, M synchronised input channels,
// and a debounced, edge-latched, maskable interrupt unit for the RAT MCU.
module rat_io_ctrl #(
  parameter int         NUM_OUT   = 4,
  parameter int         NUM_IN    = 4,
  parameter int         IRQ_CH    = 2,
  parameter logic [7:0] OUT_BASE  = 8'h40,
  parameter logic [7:0] IN_BASE   = 8'h20,
  parameter logic [7:0] IRQ_BASE  = 8'hF0,
  parameter int         DB_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  rat_io_ctrl_if.slave          bus,
  input  logic [8*NUM_IN-1:0]   IN_DATA,
  output logic [8*NUM_OUT-1:0]  OUT_DATA,
  input  logic [IRQ_CH-1:0]     BTN_IRQ,
  output logic                  INTR
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  function automatic bit windows_overlap(int a_lo, int a_n, int b_lo, int b_n);
    return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
  endfunction

  localparam bit BAD_MAP =
    windows_overlap(int'(OUT_BASE), NUM_OUT, int'(IN_BASE), NUM_IN) ||
    windows_overlap(int'(OUT_BASE), NUM_OUT, int'(IRQ_BASE), 3) ||
    windows_overlap(int'(IN_BASE), NUM_IN, int'(IRQ_BASE), 3);

  localparam bit BAD_PARAM = (NUM_OUT < 1) || (NUM_OUT > 16) || (NUM_IN < 1) || (NUM_IN > 16) ||
                             (IRQ_CH < 1) || (IRQ_CH > 8) || (DB_CYCLES < 1);

  generate
    if (BAD_MAP) begin : g_map_err
      $error("rat_io_ctrl: address windows overlap");
    end
    if (BAD_PARAM) begin : g_param_err
      $error("rat_io_ctrl: parameter out of range");
    end
  endgenerate

  logic [8*NUM_OUT-1:0] out_reg;
  logic [8*NUM_IN-1:0]  in_s1, in_s2;
  logic [IRQ_CH-1:0]    irq_s1, irq_s2, db_lvl, db_tc, pending, mask;
  logic [CW-1:0]        db_cnt [IRQ_CH];
  logic [IRQ_CH-1:0]    ack_clr, db_rise;
  logic                 ack_wr, mask_wr;
  logic [7:0]           rd_data;

  assign ack_wr  = bus.IO_STRB && (int'(bus.PORT_ID) == int'(IRQ_BASE) + 2);
  assign mask_wr = bus.IO_STRB && (int'(bus.PORT_ID) == int'(IRQ_BASE) + 1);
  assign ack_clr = ack_wr ? bus.OUT_PORT[IRQ_CH-1:0] : '0;

  // A source reaches terminal count on the edge its debounced level flips.
  always_comb begin
    db_tc = '0;
    for (int k = 0; k < IRQ_CH; k++) begin
      db_tc[k] = (irq_s2[k] != db_lvl[k]) && (db_cnt[k] == CW'(DB_CYCLES - 1));
    end
  end

  assign db_rise = db_tc & irq_s2 & ~db_lvl;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_reg <= '0;
      in_s1   <= '0;
      in_s2   <= '0;
      irq_s1  <= '0;
      irq_s2  <= '0;
      db_lvl  <= '0;
      pending <= '0;
      mask    <= '0;
      INTR    <= 1'b0;
      for (int k = 0; k < IRQ_CH; k++) db_cnt[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (bus.IO_STRB && (int'(bus.PORT_ID) == int'(OUT_BASE) + i))
          out_reg[8*i +: 8] <= bus.OUT_PORT;
      end
      in_s1  <= IN_DATA;
      in_s2  <= in_s1;
      irq_s1 <= BTN_IRQ;
      irq_s2 <= irq_s1;
      for (int k = 0; k < IRQ_CH; k++) begin
        if (irq_s2[k] == db_lvl[k]) begin
          db_cnt[k] <= '0;
        end else if (db_tc[k]) begin
          db_lvl[k] <= irq_s2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
      // A new rising edge beats a simultaneous acknowledge.
      pending <= (pending & ~ack_clr) | db_rise;
      if (mask_wr) mask <= bus.OUT_PORT[IRQ_CH-1:0];
      INTR <= |(pending & mask);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(bus.PORT_ID) == int'(IN_BASE) + i) rd_data = in_s2[8*i +: 8];
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (int'(bus.PORT_ID) == int'(OUT_BASE) + i) rd_data = out_reg[8*i +: 8];
    end
    if (bus.PORT_ID == IRQ_BASE) rd_data = 8'(pending);
    if (int'(bus.PORT_ID) == int'(IRQ_BASE) + 1) rd_data = 8'(mask);
  end

  assign bus.IN_PORT = rd_data;
  assign OUT_DATA    = out_reg;

endmodule

// File: tb/tb_rat_io_ctrl.sv
// Directed bench for rat_io_ctrl: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_rat_io_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IN_DATA = '0;
  logic [31:0] OUT_DATA;
  logic [1:0]  BTN_IRQ = '0;
  logic        INTR;

  rat_io_ctrl_if bus ();

  rat_io_ctrl #(
    .NUM_OUT(4), .NUM_IN(4), .IRQ_CH(2),
    .OUT_BASE(8'h40), .IN_BASE(8'h20), .IRQ_BASE(8'hF0), .DB_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA), .BTN_IRQ(BTN_IRQ), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] v, input string tag);
    bus.PORT_ID = port;
    expect_val({24'h0, v});
    #1;
    check(tag, {24'h0, bus.IN_PORT});
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    bus.PORT_ID  = port;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic chk_intr(input logic v, input string tag);
    expect_val({31'h0, v});
    check(tag, {31'h0, INTR});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    // Reset state
    expect_val(32'h0);
    check("rst_out_data", OUT_DATA);
    chk_intr(1'b0, "rst_intr");
    rd(8'hF0, 8'h00, "rst_stat");

    // Output write and readback
    wr(8'h41, 8'hA5);
    expect_val(32'h0000_A500);
    check("wr41_out_data", OUT_DATA);
    rd(8'h41, 8'hA5, "rd41");
    wr(8'h43, 8'h5A);
    expect_val(32'h5A00_A500);
    check("wr43_out_data", OUT_DATA);
    bus.PORT_ID = 8'h41; bus.OUT_PORT = 8'hFF; bus.IO_STRB = 1'b0;
    tick();
    expect_val(32'h5A00_A500);
    check("nostrb_hold", OUT_DATA);
    wr(8'h44, 8'h77);
    expect_val(32'h5A00_A500);
    check("unmapped_wr_hold", OUT_DATA);
    rd(8'h7F, 8'h00, "rd_unmapped");
    rd(8'h40, 8'h00, "rd40");

    // Input synchroniser latency
    bus.PORT_ID = 8'h22;
    IN_DATA[23:16] = 8'h3C;
    #1;
    expect_val(32'h0); check("in_before_e1", {24'h0, bus.IN_PORT});
    tick();
    expect_val(32'h0); check("in_after_e1", {24'h0, bus.IN_PORT});
    tick();
    expect_val(32'h3C); check("in_after_e2", {24'h0, bus.IN_PORT});
    rd(8'h21, 8'h00, "rd_in_ch1");

    // Debounce: short glitch must not set pending
    wr(8'hF1, 8'h01);
    rd(8'hF1, 8'h01, "mask_rb");
    bus.PORT_ID = 8'hF0;
    BTN_IRQ[0] = 1'b1;
    tick(); tick();
    BTN_IRQ[0] = 1'b0;
    repeat (8) tick();
    rd(8'hF0, 8'h00, "glitch_stat");
    chk_intr(1'b0, "glitch_intr");

    // Held high: pending at edge 6, INTR at edge 7
    BTN_IRQ[0] = 1'b1;
    repeat (5) tick();
    rd(8'hF0, 8'h00, "hold_e5_stat");
    tick();
    rd(8'hF0, 8'h01, "hold_e6_stat");
    chk_intr(1'b0, "hold_e6_intr");
    tick();
    chk_intr(1'b1, "hold_e7_intr");

    // Falling debounced level leaves pending alone
    BTN_IRQ[0] = 1'b0;
    repeat (8) tick();
    rd(8'hF0, 8'h01, "fall_stat");
    chk_intr(1'b1, "fall_intr");

    // Re-rise coinciding with ACK: set wins
    BTN_IRQ[0] = 1'b1;
    repeat (5) tick();
    bus.PORT_ID = 8'hF2; bus.OUT_PORT = 8'h01; bus.IO_STRB = 1'b1;
    tick();
    bus.IO_STRB = 1'b0;
    chk_intr(1'b1, "coinc_intr");
    rd(8'hF0, 8'h01, "coinc_stat");
    tick();
    chk_intr(1'b1, "coinc_intr_next");

    // ACK clears pending; INTR falls one edge later
    wr(8'hF2, 8'h01);
    chk_intr(1'b1, "ack_intr_same");
    rd(8'hF0, 8'h00, "ack_stat");
    rd(8'hF2, 8'h00, "ack_reads0");
    tick();
    chk_intr(1'b0, "ack_intr_next");

    // Masking
    wr(8'hF1, 8'h00);
    BTN_IRQ[1] = 1'b1;
    repeat (8) tick();
    rd(8'hF0, 8'h02, "mask0_stat");
    chk_intr(1'b0, "mask0_intr");
    wr(8'hF1, 8'h02);
    chk_intr(1'b0, "unmask_same");
    tick();
    chk_intr(1'b1, "unmask_next");
    wr(8'hF1, 8'hFE);
    rd(8'hF1, 8'h02, "mask_hibits");
    BTN_IRQ[1] = 1'b0;
    repeat (8) tick();
    rd(8'hF0, 8'h02, "release_stat");
    chk_intr(1'b1, "release_intr");

    // Asynchronous reset with pending, mask and outputs all live
    BTN_IRQ = 2'b00;
    #2;
    RST_N = 1'b0;
    #1;
    expect_val(32'h0);
    check("async_rst_out", OUT_DATA);
    chk_intr(1'b0, "async_rst_intr");
    tick();
    RST_N = 1'b1;
    rd(8'hF0, 8'h00, "post_rst_stat");
    rd(8'hF1, 8'h00, "post_rst_mask");
    rd(8'h43, 8'h00, "post_rst_rd43");
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
